// File: rtl/pim_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pim_pkg                                                                    |
// | Shared mode encodings, lane-count default and decoder state type.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package pim_pkg;

    localparam int         NUM_LANES_DEFAULT = 4;
    localparam logic [2:0] PIM_PARALLEL      = 3'b101;
    localparam logic [2:0] PIM_RBR           = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } pim_state_e;

    function automatic logic mode_valid(input logic [2:0] mode);
        return (mode == PIM_PARALLEL) || (mode == PIM_RBR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pim_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pim_decoder_if                                                             |
// | Input word and output beat handshakes of the PIM decoder.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface pim_decoder_if
    import pim_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT
) ();

    logic [2:0]             pim_mode_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [7*NUM_LANES-1:0] code_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [8*NUM_LANES-1:0] thermo_o;
    logic                   out_last_o;

    modport slave (
        input  pim_mode_i, in_valid_i, code_i, out_ready_i,
        output in_ready_o, out_valid_o, thermo_o, out_last_o
    );

    modport master (
        output pim_mode_i, in_valid_i, code_i, out_ready_i,
        input  in_ready_o, out_valid_o, thermo_o, out_last_o
    );

endinterface
`default_nettype wire

// File: rtl/pim_decoder_thermo_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | thermo_expand                                                              |
// | Combinational 0..8 count to 8-bit LSB-first thermometer code.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module thermo_expand (
    input  wire logic [3:0] value_i,
    output logic      [7:0] thermo_o
);

    always_comb begin
        thermo_o = '0;
        for (int i = 0; i < 8; i++) begin
            thermo_o[i] = (value_i > 4'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/pim_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pim_decoder                                                                |
// | Per-lane count to thermometer decoder, one beat (RBR) or two (PARALLEL).   |
// | Optional sticky error flag when built with PIM_DECODER_ERR_EN.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pim_decoder
    import pim_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEFAULT
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
`ifdef PIM_DECODER_ERR_EN
    input  wire logic     err_clr_i,
    output logic          err_o,
`endif
    pim_decoder_if.slave  bus
);

    logic                   mode_ok_w;
    logic                   par_w;
    logic [NUM_LANES-1:0]   sat_w;
    logic [8*NUM_LANES-1:0] th_lo_w;
    logic [8*NUM_LANES-1:0] th_hi_w;

    assign mode_ok_w = mode_valid(bus.pim_mode_i);
    assign par_w     = (bus.pim_mode_i == PIM_PARALLEL);

    // Both beats are decoded at accept time; beat 1 is parked until needed.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [6:0] code_l;
        logic [4:0] vs_l;
        logic [3:0] lo_l;
        logic [3:0] hi_l;
        logic       sat_l;

        assign code_l = bus.code_i[7*l +: 7];

        always_comb begin
            sat_l = 1'b0;
            vs_l  = 5'd0;
            lo_l  = 4'd0;
            hi_l  = 4'd0;
            if (par_w) begin
                if (code_l > 7'd16) begin
                    sat_l = 1'b1;
                    vs_l  = 5'd16;
                end else begin
                    vs_l  = code_l[4:0];
                end
                if (vs_l > 5'd8) begin
                    lo_l = 4'd8;
                    hi_l = 4'(vs_l - 5'd8);
                end else begin
                    lo_l = vs_l[3:0];
                end
            end else begin
                if (code_l[3:0] > 4'd8) begin
                    sat_l = 1'b1;
                    lo_l  = 4'd8;
                end else begin
                    lo_l  = code_l[3:0];
                end
            end
        end

        assign sat_w[l] = sat_l;

        thermo_expand u_lo (
            .value_i  (lo_l),
            .thermo_o (th_lo_w[8*l +: 8])
        );

        thermo_expand u_hi (
            .value_i  (hi_l),
            .thermo_o (th_hi_w[8*l +: 8])
        );
    end

    pim_state_e             state_q;
    logic                   par_q;
    logic [8*NUM_LANES-1:0] beat1_q;
    logic [8*NUM_LANES-1:0] thermo_q;
    logic                   last_q;

    logic final_w;
    logic in_ready_w;
    logic accept_w;
    logic beat_xfer_w;

    assign final_w     = ((state_q == ST_BEAT0) && !par_q) || (state_q == ST_BEAT1);
    assign in_ready_w  = (state_q == ST_IDLE) || (final_w && bus.out_ready_i);
    assign accept_w    = bus.in_valid_i && in_ready_w;
    assign beat_xfer_w = (state_q != ST_IDLE) && bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            par_q    <= 1'b0;
            beat1_q  <= '0;
            thermo_q <= '0;
            last_q   <= 1'b0;
        end else begin
            if (beat_xfer_w) begin
                if ((state_q == ST_BEAT0) && par_q) begin
                    state_q  <= ST_BEAT1;
                    thermo_q <= beat1_q;
                    last_q   <= 1'b1;
                end else begin
                    state_q  <= ST_IDLE;
                    par_q    <= 1'b0;
                    beat1_q  <= '0;
                    thermo_q <= '0;
                    last_q   <= 1'b0;
                end
            end
            // A word with an invalid mode is consumed here but leaves no trace.
            if (accept_w && mode_ok_w) begin
                state_q  <= ST_BEAT0;
                par_q    <= par_w;
                beat1_q  <= th_hi_w;
                thermo_q <= th_lo_w;
                last_q   <= !par_w;
            end
        end
    end

    assign bus.in_ready_o  = in_ready_w;
    assign bus.out_valid_o = (state_q != ST_IDLE);
    assign bus.thermo_o    = thermo_q;
    assign bus.out_last_o  = last_q;

`ifdef PIM_DECODER_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept_w && (!mode_ok_w || (|sat_w))) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_sat_w;
    assign unused_sat_w = ^sat_w;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pim_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pim_decoder                                                             |
// | Directed stimulus, queue-based beat model and per-cycle comparison.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pim_decoder;
    import pim_pkg::*;

    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pim_decoder_if #(.NUM_LANES(NL)) bus ();

`ifdef PIM_DECODER_ERR_EN
    logic err_o;
    logic err_clr = 1'b0;
`endif

    pim_decoder #(.NUM_LANES(NL)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
`ifdef PIM_DECODER_ERR_EN
        .err_clr_i (err_clr),
        .err_o     (err_o),
`endif
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of pending beats ----------------
    typedef struct packed {
        logic [8*NL-1:0] th;
        logic            last;
    } beat_t;

    beat_t mq[$];
    bit    armed = 1'b0;
    bit    m_err = 1'b0;
    bit    m_acc;
    bit    m_bad;

    function automatic logic [7:0] therm(input int n);
        int t;
        t = (1 << n) - 1;
        return t[7:0];
    endfunction

    function automatic logic m_ready();
        return (mq.size() == 0) || ((mq.size() == 1) && bus.out_ready_i);
    endfunction

    task automatic push_word(input logic [2:0] m, input logic [7*NL-1:0] c, output bit bad);
        beat_t b0;
        beat_t b1;
        int    raw;
        bad = !((m == PIM_PARALLEL) || (m == PIM_RBR));
        b0  = '0;
        b1  = '0;
        for (int l = 0; l < NL; l++) begin
            if (m == PIM_RBR) begin
                raw = int'(c[7*l +: 4]);
                if (raw > 8) begin bad = 1'b1; raw = 8; end
                b0.th[8*l +: 8] = therm(raw);
            end else if (m == PIM_PARALLEL) begin
                raw = int'(c[7*l +: 7]);
                if (raw > 16) begin bad = 1'b1; raw = 16; end
                b0.th[8*l +: 8] = therm(raw < 8 ? raw : 8);
                b1.th[8*l +: 8] = therm(raw > 8 ? raw - 8 : 0);
            end
        end
        b0.last = (m == PIM_RBR);
        b1.last = 1'b1;
        if (m == PIM_RBR) mq.push_back(b0);
        if (m == PIM_PARALLEL) begin
            mq.push_back(b0);
            mq.push_back(b1);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
            armed = 1'b1;
        end else if (armed) begin
            m_acc = bus.in_valid_i && m_ready();
            m_bad = 1'b0;
            if ((mq.size() > 0) && bus.out_ready_i) void'(mq.pop_front());
            if (m_acc) push_word(bus.pim_mode_i, bus.code_i, m_bad);
`ifdef PIM_DECODER_ERR_EN
            if (m_acc && m_bad) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", bus.in_ready_o, m_ready());
            chk("out_valid", bus.out_valid_o, mq.size() > 0);
            chk("thermo", bus.thermo_o, (mq.size() > 0) ? mq[0].th : '0);
            chk("out_last", bus.out_last_o, (mq.size() > 0) ? mq[0].last : 1'b0);
`ifdef PIM_DECODER_ERR_EN
            chk("err", err_o, m_err);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [7*NL-1:0] w4(input int a, input int b, input int c, input int d);
        return {7'(a), 7'(b), 7'(c), 7'(d)};
    endfunction

    task automatic cyc(input logic v, input logic [2:0] m, input logic [7*NL-1:0] c, input logic ordy);
        bus.in_valid_i  = v;
        bus.pim_mode_i  = m;
        bus.code_i      = c;
        bus.out_ready_i = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.pim_mode_i  = 3'b000;
        bus.code_i      = '0;
        bus.out_ready_i = 1'b1;

        rst = 1'b1;
        cyc(0, 3'b000, '0, 1);
        cyc(0, 3'b000, '0, 1);
        chk("rst_valid", bus.out_valid_o, 1'b0);
        chk("rst_thermo", bus.thermo_o, 32'h0);
        chk("rst_last", bus.out_last_o, 1'b0);
        rst = 1'b0;
        cyc(0, 3'b000, '0, 1);
        chk("rst_ready", bus.in_ready_o, 1'b1);

        // single-beat RBR word
        cyc(1, PIM_RBR, w4(3, 0, 8, 5), 1);
        chk("rbr_valid", bus.out_valid_o, 1'b1);
        chk("rbr_thermo", bus.thermo_o, 32'h0700FF1F);
        chk("rbr_last", bus.out_last_o, 1'b1);
        cyc(0, PIM_RBR, '0, 1);
        chk("rbr_done", bus.out_valid_o, 1'b0);

        // two-beat PARALLEL word
        cyc(1, PIM_PARALLEL, w4(12, 16, 4, 0), 1);
        chk("par_b0", bus.thermo_o, 32'hFFFF0F00);
        chk("par_b0_last", bus.out_last_o, 1'b0);
        cyc(0, 3'b000, '0, 1);
        chk("par_b1", bus.thermo_o, 32'h0FFF0000);
        chk("par_b1_last", bus.out_last_o, 1'b1);
        cyc(0, 3'b000, '0, 1);

        // saturation, lanes independent
        cyc(1, PIM_RBR, w4(13, 1, 7'h7D, 0), 1);
        chk("rbr_sat", bus.thermo_o, 32'hFF01FF00);
`ifdef PIM_DECODER_ERR_EN
        chk("err_set_rbr", err_o, 1'b1);
        err_clr = 1'b1;
        cyc(0, 3'b000, '0, 1);
        err_clr = 1'b0;
        chk("err_clr", err_o, 1'b0);
`else
        cyc(0, 3'b000, '0, 1);
`endif
        cyc(1, PIM_PARALLEL, w4(100, 9, 100, 17), 1);
        chk("par_sat_b0", bus.thermo_o, 32'hFFFFFFFF);
        cyc(0, 3'b000, '0, 1);
        chk("par_sat_b1", bus.thermo_o, 32'hFF01FFFF);
`ifdef PIM_DECODER_ERR_EN
        chk("err_set_par", err_o, 1'b1);
`endif
        cyc(0, 3'b000, '0, 1);

        // backpressure in BEAT0 with mode flips on the input
        cyc(1, PIM_PARALLEL, w4(5, 10, 0, 8), 1);
        chk("hold_b0", bus.thermo_o, 32'h1FFF00FF);
        for (int i = 0; i < 3; i++) begin
            cyc(1, (i % 2 == 0) ? PIM_RBR : 3'b000, w4(1, 1, 1, 1), 0);
            chk("hold_thermo", bus.thermo_o, 32'h1FFF00FF);
            chk("hold_ready", bus.in_ready_o, 1'b0);
            chk("hold_last", bus.out_last_o, 1'b0);
        end
        cyc(0, PIM_RBR, '0, 1);
        chk("hold_b1", bus.thermo_o, 32'h00030000);
        chk("hold_b1_last", bus.out_last_o, 1'b1);
        cyc(0, 3'b000, '0, 1);

        // back-to-back streams
        for (int i = 0; i < 4; i++) begin
            cyc(1, PIM_RBR, w4(i, i + 1, i + 2, i + 3), 1);
            chk("b2b_rbr_valid", bus.out_valid_o, 1'b1);
            chk("b2b_rbr_ready", bus.in_ready_o, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1, PIM_PARALLEL, w4(9 + i, 15 - i, i, 16), 1);
        end
        cyc(0, 3'b000, '0, 1);
        cyc(0, 3'b000, '0, 1);

        // reset during BEAT0 discards the second beat
        cyc(1, PIM_PARALLEL, w4(12, 12, 12, 12), 1);
        chk("mid_b0", bus.thermo_o, 32'hFFFFFFFF);
        rst = 1'b1;
        cyc(0, 3'b000, '0, 1);
        rst = 1'b0;
        chk("mid_rst_valid", bus.out_valid_o, 1'b0);
        chk("mid_rst_thermo", bus.thermo_o, 32'h0);
        cyc(0, 3'b000, '0, 1);
        chk("mid_no_b1", bus.out_valid_o, 1'b0);

        // invalid modes are consumed and dropped
        cyc(1, 3'b000, w4(1, 2, 3, 4), 1);
        chk("drop_valid", bus.out_valid_o, 1'b0);
        chk("drop_ready", bus.in_ready_o, 1'b1);
`ifdef PIM_DECODER_ERR_EN
        chk("err_invalid", err_o, 1'b1);
`endif
        cyc(1, 3'b111, w4(4, 3, 2, 1), 1);
        chk("drop_valid2", bus.out_valid_o, 1'b0);
        cyc(0, 3'b000, '0, 1);
        cyc(0, 3'b000, '0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
